// File: rtl/enc_pkg.sv
// enc_pkg: shared types and constants for the sequential priority encoder.
//   state_e  : controller states (IDLE waits for a vector, DRAIN emits indices)
//   N_DEF    : default request-vector width
//   W_DEF    : default index width
//   clog2()  : ceiling log2, used to size the index from the vector width
package enc_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_e;

   localparam int unsigned N_DEF = 8;
   localparam int unsigned W_DEF = 3;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned p = 1; p < v; p = p << 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// prio_enc_comb: combinational highest-set-bit finder.
//   vec_i [N-1:0] : bitmap to search
//   idx_o [W-1:0] : index of the highest set bit (0 when vec_i is all-zero)
//   any_o         : at least one bit of vec_i is set
module prio_enc_comb #(
   parameter int unsigned N = 8,
   parameter int unsigned W = 3
) (
   input  logic [N-1:0] vec_i,
   output logic [W-1:0] idx_o,
   output logic         any_o
);

   always_comb begin
      idx_o = '0;
      any_o = |vec_i;
      // Ascending scan: the last hit wins, i.e. the highest set bit.
      for (int unsigned i = 0; i < N; i++) begin
         if (vec_i[i]) begin
            idx_o = W'(i);
         end
      end
   end

endmodule

// File: rtl/prio_enc_drain.sv
// prio_enc_drain: sequential priority encoder.
// Latches a multi-hot request vector over a valid/ready handshake, then emits
// the index of every set bit, highest first, one per output handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   en                  : gates vector acceptance only
//   flush               : synchronous abort of the current drain
//   in_valid/in_ready   : input handshake, in_vec is the request bitmap
//   out_valid/out_ready : output handshake, out_idx is the current index
//   out_last            : current index is the final pending bit
//   zero_flag           : one-cycle pulse after an all-zero vector is accepted
//   busy                : controller is draining
module prio_enc_drain
   import enc_pkg::*;
#(
   parameter int unsigned N = N_DEF,
   parameter int unsigned W = clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_vec,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic         out_last,
   output logic         zero_flag,
   output logic         busy
);

   state_e         state_q, state_d;
   logic [N-1:0]   pending_q, pending_d;
   logic           zero_flag_q, zero_flag_d;

   logic [W-1:0]   hi_idx;
   logic           hi_any;

   prio_enc_comb #(
      .N (N),
      .W (W)
   ) u_find (
      .vec_i (pending_q),
      .idx_o (hi_idx),
      .any_o (hi_any)
   );

   // Outputs depend only on registered state, so in_vec never reaches them.
   assign out_idx   = hi_idx;
   assign out_last  = hi_any && ((pending_q & (pending_q - N'(1))) == '0);
   assign zero_flag = zero_flag_q;
   assign busy      = (state_q == DRAIN);

   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      zero_flag_d = 1'b0;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = en;
            if (in_valid && en) begin
               if (in_vec != '0) begin
                  pending_d = in_vec;
                  state_d   = DRAIN;
               end else begin
                  zero_flag_d = 1'b1;
               end
            end
         end
         DRAIN: begin
            out_valid = 1'b1;
            // flush wins over a coincident handshake; that index still counts
            // as delivered, nothing further follows.
            if (flush) begin
               pending_d = '0;
               state_d   = IDLE;
            end else if (out_ready) begin
               pending_d = pending_q & ~(N'(1) << hi_idx);
               if (out_last) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            pending_d = '0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         zero_flag_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         zero_flag_q <= zero_flag_d;
      end
   end

endmodule

// File: tb/tb_prio_enc_drain.sv
module tb_prio_enc_drain;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_vec = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [2:0] out_idx;
   logic       out_last;
   logic       zero_flag;
   logic       busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   prio_enc_drain #(.N(8), .W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .zero_flag (zero_flag),
      .busy      (busy)
   );

   typedef struct {
      logic [7:0] vec;
      int         first;
      int         last;
      int         nbits;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // advance one clock; inputs are driven and outputs sampled 2ns after the edge
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic accept(input logic [7:0] v);
      en       = 1'b1;
      in_valid = 1'b1;
      in_vec   = v;
      step();
      in_valid = 1'b0;
      in_vec   = '0;
   endtask

   // reference model state: remaining indices in delivery order
   int q[$];
   int zero_exp;

   initial begin
      tbl[0] = '{8'hA4, 7, 2, 3};
      tbl[1] = '{8'h80, 7, 7, 1};
      tbl[2] = '{8'h01, 0, 0, 1};
      tbl[3] = '{8'hFF, 7, 0, 8};
      tbl[4] = '{8'h5A, 6, 1, 4};
      tbl[5] = '{8'h3C, 5, 2, 4};

      // 1. reset state
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_zero_flag", zero_flag, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_last", out_last, 0);
      step();
      rst_n = 1'b1;
      step();

      // 2. A4 with out_ready high
      out_ready = 1'b1;
      accept(8'hA4);
      chk("a4_v1", out_valid, 1);
      chk("a4_i1", out_idx, 7);
      chk("a4_l1", out_last, 0);
      chk("a4_rdy1", in_ready, 0);
      step();
      chk("a4_i2", out_idx, 5);
      chk("a4_l2", out_last, 0);
      step();
      chk("a4_i3", out_idx, 2);
      chk("a4_l3", out_last, 1);
      step();
      chk("a4_done_rdy", in_ready, 1);
      chk("a4_done_valid", out_valid, 0);

      // 3. 81 with stalled consumer
      out_ready = 1'b0;
      accept(8'h81);
      for (int i = 0; i < 3; i++) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_idx", out_idx, 7);
         chk("hold_last", out_last, 0);
         step();
      end
      out_ready = 1'b1;
      chk("hold_idx7", out_idx, 7);
      step();
      chk("hold_idx0", out_idx, 0);
      chk("hold_last0", out_last, 1);
      step();
      chk("hold_idle", busy, 0);

      // 4. zero vector
      accept(8'h00);
      chk("zero_flag1", zero_flag, 1);
      chk("zero_valid", out_valid, 0);
      chk("zero_busy", busy, 0);
      step();
      chk("zero_flag_drop", zero_flag, 0);

      // 5. en low blocks acceptance, en low in DRAIN has no effect
      en = 1'b0;
      in_valid = 1'b1;
      in_vec = 8'h30;
      #1;
      chk("en0_rdy", in_ready, 0);
      step();
      chk("en0_busy", busy, 0);
      chk("en0_valid", out_valid, 0);
      in_valid = 1'b0;
      accept(8'h30);
      en = 1'b0;
      chk("en_d_i1", out_idx, 5);
      step();
      chk("en_d_i2", out_idx, 4);
      chk("en_d_l2", out_last, 1);
      step();
      chk("en_d_idle", out_valid, 0);
      en = 1'b1;

      // 6. flush coincident with handshake on idx 6
      accept(8'hFF);
      chk("fl_i7", out_idx, 7);
      step();
      chk("fl_i6", out_idx, 6);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fl_valid", out_valid, 0);
      chk("fl_rdy", in_ready, 1);
      accept(8'h01);
      chk("fl_next_i", out_idx, 0);
      chk("fl_next_l", out_last, 1);
      step();
      // flush in IDLE ignored with a coincident accept
      flush = 1'b1;
      accept(8'h02);
      flush = 1'b0;
      chk("fl_idle_acc", out_idx, 1);
      step();

      // reset during DRAIN
      out_ready = 1'b0;
      accept(8'hF0);
      chk("rstd_valid_pre", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("rstd_valid", out_valid, 0);
      chk("rstd_busy", busy, 0);
      step();
      rst_n = 1'b1;
      step();
      chk("rstd_rdy", in_ready, 1);
      out_ready = 1'b1;

      // table-driven vectors
      foreach (tbl[t]) begin
         accept(tbl[t].vec);
         for (int j = 0; j < tbl[t].nbits; j++) begin
            chk("tbl_valid", out_valid, 1);
            chk("tbl_last", out_last, (j == tbl[t].nbits - 1) ? 1 : 0);
            if (j == 0) chk("tbl_first", out_idx, tbl[t].first);
            if (j == tbl[t].nbits - 1) chk("tbl_lastidx", out_idx, tbl[t].last);
            step();
         end
         chk("tbl_rdy", in_ready, 1);
      end

      // randomized run against a queue model
      q.delete();
      zero_exp = 0;
      for (int c = 0; c < 3000; c++) begin
         logic [7:0] v;
         v = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
         en        = ($urandom_range(0, 3) != 0);
         in_valid  = $urandom_range(0, 1);
         in_vec    = v;
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         #1;
         chk("r_valid", out_valid, (q.size() > 0) ? 1 : 0);
         chk("r_rdy", in_ready, (q.size() == 0 && en) ? 1 : 0);
         chk("r_busy", busy, (q.size() > 0) ? 1 : 0);
         chk("r_idx", out_idx, (q.size() > 0) ? q[0] : 0);
         chk("r_last", out_last, (q.size() == 1) ? 1 : 0);
         chk("r_zero", zero_flag, zero_exp);
         zero_exp = 0;
         if (q.size() > 0) begin
            if (flush) q.delete();
            else if (out_ready) void'(q.pop_front());
         end else if (en && in_valid) begin
            if (v == 8'h00) zero_exp = 1;
            else for (int i = 7; i >= 0; i--) if (v[i]) q.push_back(i);
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prio_enc_drain.md
Name: prio_enc_drain

Overview:
- Sequential priority encoder; it is the encode-direction counterpart of the team's one-hot decoders.
- Accepts a multi-hot request vector over a valid/ready handshake and latches it.
- Emits the index of every set bit, one per output handshake, highest index first, then frees itself for the next vector.
- Used to turn key/interrupt bitmaps into index streams for 7-segment display and event logic.

Parameters:
- N, 8, width of the request vector.
- W, 3, index width; must equal clog2(N).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  enable; gates only vector acceptance
- flush  in  1  synchronous abort of the current drain
- in_valid  in  1  in_vec is valid
- in_ready  out  1  block can accept a vector
- in_vec  in  N  request bitmap
- out_valid  out  1  out_idx is valid
- out_ready  in  1  consumer accepts out_idx
- out_idx  out  W  index of the highest pending set bit
- out_last  out  1  current index is the final pending bit
- zero_flag  out  1  one-cycle pulse when an all-zero vector is accepted
- busy  out  1  state is DRAIN

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, pending=0, zero_flag=0.
  - Hence in_ready=en, out_valid=0, out_idx=0, out_last=0, busy=0.
  - Reset asserted mid-drain drops out_valid immediately and discards pending.
- States: IDLE, DRAIN. pending is an N-bit register.
- IDLE:
  - in_ready = en (combinational). out_valid=0.
  - Accept occurs when in_valid & in_ready at an edge.
  - in_vec!=0: pending<=in_vec, go to DRAIN.
  - in_vec==0: stay in IDLE; zero_flag=1 for exactly the next cycle.
- DRAIN:
  - in_ready=0, out_valid=1.
  - out_idx = highest set bit of pending; combinational from the register, so no latch on the input path.
  - out_last = 1 when pending has exactly one bit set.
  - On out_valid & out_ready: clear bit out_idx in pending. If out_last, return to IDLE; else stay in DRAIN.
  - With out_ready=0: out_idx and out_last must be held stable (valid must not drop).
- Latency and throughput:
  - Vector accepted at edge k gives out_valid=1 in cycle k+1.
  - With out_ready held high: one index per cycle, so popcount(in_vec) cycles.
  - in_ready rises the cycle after the last handshake, giving a 1-cycle bubble between vectors.
- en:
  - en=0 blocks acceptance in IDLE.
  - en has no effect in DRAIN; the drain completes.
- flush:
  - Sampled at an edge with state=DRAIN: state<=IDLE, pending<=0.
  - flush has priority over a coincident output handshake. The handshake index that cycle is counted as delivered; no further indices follow.
  - flush in IDLE is ignored; a coincident accept still proceeds.
- Encoding rule: for bitmap b, out_idx = max{i : b[i]=1}. All indices are unsigned W-bit values; no wrap-around is possible since pending only loses bits.
- No combinational path from in_vec to any output.

Decomposition:
- Package enc_pkg holds:
  - state enum {IDLE, DRAIN}
  - default N=8, W=3
  - a clog2 helper constant function
- Sub-module prio_enc_comb (parameters N, W): combinational highest-set-bit finder over pending, producing idx[W-1:0] and any.
- out_last is derived in the top level as (pending & (pending-1))==0 with any=1.

Test Plan:
1. Reset release with en=1 -> in_ready=1, out_valid=0, zero_flag=0. Reset asserted during DRAIN -> out_valid=0 in the same cycle, in_ready=1 after release.
2. in_vec=8'b1010_0100, out_ready=1 -> out_idx 7,5,2 on consecutive cycles starting k+1; out_last=1 only with idx 2; in_ready=1 at k+4.
3. in_vec=8'h81, out_ready=0 for 3 cycles then 1 -> out_idx=7 and out_last=0 held stable 3 cycles; then idx 0 with out_last=1; then IDLE.
4. in_vec=8'h00 accepted -> zero_flag=1 for one cycle, out_valid stays 0, busy stays 0.
5. en=0 with in_valid=1 in IDLE -> in_ready=0, no accept. Vector 8'h30 accepted, then en=0 during DRAIN -> idx 5,4 still delivered.
6. in_vec=8'hFF; flush=1 coincident with the handshake on idx 6 -> IDLE next cycle, no idx 5..0. Then in_vec=8'h01 -> idx 0, out_last=1.
